// File: rtl/bram_arb_pkg.sv
// Shared types for the port-A arbiter: FSM states, requester id, byte-enable constant.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bram_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RD_ADDR   = 3'd1,
    RD_DATA   = 3'd2,
    WR        = 3'd3,
    RMW_ADDR  = 3'd4,
    RMW_MERGE = 3'd5,
    RMW_WR    = 3'd6
  } state_t;

  // Requester 0 is the CPU (priority), requester 1 the DMA/loader.
  typedef logic req_id_t;

  localparam int DEF_DATA_W = 32;

  // All byte lanes enabled for the default 32-bit word.
  localparam logic [DEF_DATA_W/8-1:0] BE_FULL = '1;

endpackage

// File: rtl/bram_byte_merge.sv
// Per-byte merge of new write data over the old RAM word.
// Latency: combinational.
// Backpressure: none.
module bram_byte_merge #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W/8-1:0] be_i,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W-1:0]   old_i,
  output logic [DATA_W-1:0]   merged_o
);

  // Enabled lanes take the new byte, the rest keep the old word's byte.
  always_comb begin
    merged_o = old_i;
    for (int i = 0; i < DATA_W/8; i++) begin
      if (be_i[i]) merged_o[i*8 +: 8] = wdata_i[i*8 +: 8];
    end
  end

endmodule

// File: rtl/bram_port_a_arbiter.sv
// Two-requester arbiter for RAM port A with byte-masked writes via read-modify-write.
// Latency: ack -> rvalid 2 cycles; ack -> ram_wren 1 cycle (full write) or 3 cycles (partial).
// Backpressure: one command at a time; requests wait (req held) until the FSM is back in IDLE.
module bram_port_a_arbiter
  import bram_arb_pkg::*;
#(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 13,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                req0,
  input  logic                req1,
  input  logic                we0,
  input  logic                we1,
  input  logic [DATA_W/8-1:0] be0,
  input  logic [DATA_W/8-1:0] be1,
  input  logic [ADDR_W-1:0]   addr0,
  input  logic [ADDR_W-1:0]   addr1,
  input  logic [DATA_W-1:0]   wdata0,
  input  logic [DATA_W-1:0]   wdata1,
  output logic                ack0,
  output logic                ack1,
  output logic                rvalid0,
  output logic                rvalid1,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic                ram_wren,
  output logic [ADDR_W-1:0]   ram_addr,
  output logic [DATA_W-1:0]   ram_data,
  input  logic [DATA_W-1:0]   ram_q
);

  localparam int BE_W = DATA_W/8;
  localparam int SW   = $clog2(STARVE_LIMIT + 1);
  localparam logic [BE_W-1:0] BE_ALL = '1;
  localparam logic [SW-1:0]   S_LIM  = SW'(STARVE_LIMIT);

  state_t              state_q, state_d;
  logic                ack0_q, ack0_d, ack1_q, ack1_d;
  logic                rvalid0_q, rvalid0_d, rvalid1_q, rvalid1_d;
  logic                busy_q, busy_d;
  logic                ram_wren_q, ram_wren_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic [SW-1:0]       starve_q, starve_d;
  req_id_t             cmd_id_q, cmd_id_d;
  logic                cmd_we_q, cmd_we_d;
  logic [BE_W-1:0]     cmd_be_q, cmd_be_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;

  logic                grant_pending;
  logic                grant;
  logic                win1;
  logic [DATA_W-1:0]   merged;

  // The ack cycle is spent in IDLE; the command state is entered on the following edge.
  assign grant_pending = ack0_q | ack1_q;
  assign win1          = req1 & (~req0 | (starve_q == S_LIM));
  assign grant         = (state_q == IDLE) & ~grant_pending & (req0 | req1);

  bram_byte_merge #(.DATA_W(DATA_W)) u_merge (
    .be_i     (cmd_be_q),
    .wdata_i  (cmd_wdata_q),
    .old_i    (ram_q),
    .merged_o (merged)
  );

  // State register and all registered outputs / command capture.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      busy_q      <= 1'b0;
      ram_wren_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      starve_q    <= '0;
      cmd_id_q    <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_be_q    <= '0;
      cmd_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      ack0_q      <= ack0_d;
      ack1_q      <= ack1_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      busy_q      <= busy_d;
      ram_wren_q  <= ram_wren_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      starve_q    <= starve_d;
      cmd_id_q    <= cmd_id_d;
      cmd_we_q    <= cmd_we_d;
      cmd_be_q    <= cmd_be_d;
      cmd_wdata_q <= cmd_wdata_d;
    end
  end

  // Next state: leave IDLE once the captured command has been acked; null writes pass through WR.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (grant_pending) begin
          if (!cmd_we_q)                                 state_d = RD_ADDR;
          else if (cmd_be_q == BE_ALL || cmd_be_q == '0) state_d = WR;
          else                                           state_d = RMW_ADDR;
        end
      end
      RD_ADDR:   state_d = RD_DATA;
      RD_DATA:   state_d = IDLE;
      WR:        state_d = IDLE;
      RMW_ADDR:  state_d = RMW_MERGE;
      RMW_MERGE: state_d = RMW_WR;
      RMW_WR:    state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // Outputs, arbitration and command capture, all registered from the next state.
  always_comb begin
    ack0_d      = 1'b0;
    ack1_d      = 1'b0;
    ram_addr_d  = ram_addr_q;
    ram_data_d  = ram_data_q;
    starve_d    = starve_q;
    cmd_id_d    = cmd_id_q;
    cmd_we_d    = cmd_we_q;
    cmd_be_d    = cmd_be_q;
    cmd_wdata_d = cmd_wdata_q;

    if (grant) begin
      ack0_d      = ~win1;
      ack1_d      = win1;
      cmd_id_d    = req_id_t'(win1);
      cmd_we_d    = win1 ? we1    : we0;
      cmd_be_d    = win1 ? be1    : be0;
      cmd_wdata_d = win1 ? wdata1 : wdata0;
      ram_addr_d  = win1 ? addr1  : addr0;
      if (win1)                 starve_d = '0;
      else if (starve_q != S_LIM) starve_d = starve_q + SW'(1);
    end
    // Requester 1 not waiting means nobody is being starved.
    if (!req1) starve_d = '0;

    if (state_d == WR)     ram_data_d = cmd_wdata_q;
    if (state_d == RMW_WR) ram_data_d = merged;

    ram_wren_d = ((state_d == WR) && (cmd_be_q != '0)) || (state_d == RMW_WR);
    rvalid0_d  = (state_d == RD_DATA) && (cmd_id_q == 1'b0);
    rvalid1_d  = (state_d == RD_DATA) && (cmd_id_q == 1'b1);
    busy_d     = (state_d != IDLE);
  end

  assign ack0     = ack0_q;
  assign ack1     = ack1_q;
  assign rvalid0  = rvalid0_q;
  assign rvalid1  = rvalid1_q;
  assign busy     = busy_q;
  assign ram_wren = ram_wren_q;
  assign ram_addr = ram_addr_q;
  assign ram_data = ram_data_q;
  assign rdata    = (state_q == RD_DATA) ? ram_q : '0;

endmodule

// File: tb/tb_bram_port_a_arbiter.sv
// Bench for bram_port_a_arbiter: directed scenarios plus random traffic against a word-level model.
// Latency: n/a.
// Backpressure: n/a.
module tb_bram_port_a_arbiter;
  import bram_arb_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [3:0]  be0 = 0, be1 = 0;
  logic [12:0] addr0 = 0, addr1 = 0;
  logic [31:0] wdata0 = 0, wdata1 = 0;
  logic        ack0, ack1, rvalid0, rvalid1, busy, ram_wren;
  logic [31:0] rdata, ram_data;
  logic [12:0] ram_addr;
  logic [31:0] ram_q = 0;

  logic [31:0] mem     [0:8191];
  logic [31:0] ref_mem [0:8191];

  int n_checks = 0;
  int n_errors = 0;
  int wren_total = 0;
  int exp_wren_total = 0;
  logic [31:0] last_rdata;

  always #5 clock = ~clock;

  bram_port_a_arbiter #(.DATA_W(32), .ADDR_W(13), .STARVE_LIMIT(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .busy(busy), .ram_wren(ram_wren),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q)
  );

  // Block RAM port A: registered read, read-before-write.
  always @(posedge clock) begin
    if (ram_wren) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  always @(negedge clock) if (ram_wren) wren_total++;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge_word(input logic [31:0] old, input logic [31:0] wd,
                                             input logic [3:0] be);
    logic [31:0] r = 0;
    for (int i = 0; i < 4; i++)
      r = r | ((be[i] ? ((wd >> (8*i)) & 32'hFF) : ((old >> (8*i)) & 32'hFF)) << (8*i));
    return r;
  endfunction

  task automatic drive(input int id, input logic r, input logic we, input logic [3:0] be,
                       input logic [12:0] a, input logic [31:0] wd);
    if (id == 0) begin req0 = r; we0 = we; be0 = be; addr0 = a; wdata0 = wd; end
    else         begin req1 = r; we1 = we; be1 = be; addr1 = a; wdata1 = wd; end
  endtask

  // Issue one command and check its whole response window against the model.
  task automatic run_cmd(input int id, input logic we, input logic [3:0] be,
                         input logic [12:0] a, input logic [31:0] wd, input string tag);
    logic got_ack = 0;
    int wren_at, busy_len;
    logic [31:0] exp_word;
    @(negedge clock);
    drive(id, 1'b1, we, be, a, wd);
    for (int k = 0; k < 30 && !got_ack; k++) begin
      @(negedge clock);
      if ((id == 0) ? ack0 : ack1) got_ack = 1;
    end
    drive(id, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk($sformatf("%s ack", tag), {31'b0, got_ack}, 32'd1);
    if (!got_ack) return;
    exp_word = we ? merge_word(ref_mem[a], wd, be) : ref_mem[a];
    if (!we)             begin wren_at = 0; busy_len = 2; end
    else if (be == 4'h0) begin wren_at = 0; busy_len = 1; end
    else if (be == 4'hF) begin wren_at = 1; busy_len = 1; end
    else                 begin wren_at = 3; busy_len = 3; end
    for (int k = 1; k <= 5; k++) begin
      @(negedge clock);
      chk($sformatf("%s rvalid@%0d", tag, k), {31'b0, (id == 0) ? rvalid0 : rvalid1},
          {31'b0, (!we && k == 2)});
      chk($sformatf("%s other_rvalid@%0d", tag, k), {31'b0, (id == 0) ? rvalid1 : rvalid0}, 0);
      chk($sformatf("%s wren@%0d", tag, k), {31'b0, ram_wren}, {31'b0, (k == wren_at)});
      chk($sformatf("%s busy@%0d", tag, k), {31'b0, busy}, {31'b0, (k <= busy_len)});
      if (k == wren_at) begin
        chk($sformatf("%s ram_data", tag), ram_data, exp_word);
        chk($sformatf("%s ram_addr", tag), {19'b0, ram_addr}, {19'b0, a});
      end
      if (!we && k == 2) begin
        chk($sformatf("%s rdata", tag), rdata, exp_word);
        last_rdata = rdata;
      end
    end
    if (wren_at != 0) begin
      ref_mem[a] = exp_word;
      exp_wren_total++;
    end
  endtask

  initial begin
    int order[$];
    int cnt, e, ack1_seen, t;
    logic seen, was_busy;

    for (int i = 0; i < 8192; i++) begin mem[i] = 0; ref_mem[i] = 0; end
    mem[13'h0005] = 32'h11223344; ref_mem[13'h0005] = 32'h11223344;
    mem[13'h0010] = 32'hAABBCCDD; ref_mem[13'h0010] = 32'hAABBCCDD;
    mem[13'h0011] = 32'h55667788; ref_mem[13'h0011] = 32'h55667788;
    mem[13'h0040] = 32'h0BADF00D; ref_mem[13'h0040] = 32'h0BADF00D;

    // Reset state.
    repeat (3) @(negedge clock);
    chk("reset ctrl", {26'b0, ack0, ack1, rvalid0, rvalid1, busy, ram_wren}, 0);
    chk("reset ram_addr", {19'b0, ram_addr}, 0);
    chk("reset ram_data", ram_data, 0);
    chk("reset rdata", rdata, 0);
    reset_n = 1'b1;

    // Directed reads / writes.
    run_cmd(0, 1'b0, 4'h0, 13'h0005, 32'h0, "rd5");
    chk("rd5 value", last_rdata, 32'h11223344);
    run_cmd(1, 1'b1, BE_FULL, 13'h1FFF, 32'hDEADBEEF, "wrtop");
    run_cmd(0, 1'b0, 4'h0, 13'h1FFF, 32'h0, "rdtop");
    chk("rdtop value", last_rdata, 32'hDEADBEEF);
    run_cmd(0, 1'b0, 4'h0, 13'h0000, 32'h0, "rd0 nowrap");
    chk("rd0 value", last_rdata, 32'h0);
    run_cmd(0, 1'b1, 4'b0101, 13'h0010, 32'h11223344, "rmw");
    run_cmd(1, 1'b0, 4'h0, 13'h0010, 32'h0, "rdrmw");
    chk("rmw value", last_rdata, 32'hAA22CC44);
    run_cmd(1, 1'b0, 4'h0, 13'h0011, 32'h0, "neigh");
    chk("neigh value", last_rdata, 32'h55667788);
    run_cmd(1, 1'b1, 4'h0, 13'h0010, 32'hFFFFFFFF, "null");

    // Both requesters held: requester 1 gets one grant after every STARVE_LIMIT grants to 0.
    @(negedge clock);
    drive(0, 1'b1, 1'b0, 4'h0, 13'h0005, 32'h0);
    drive(1, 1'b1, 1'b0, 4'h0, 13'h0011, 32'h0);
    for (int k = 0; k < 300 && order.size() < 10; k++) begin
      @(negedge clock);
      if (ack0) order.push_back(0);
      if (ack1) order.push_back(1);
    end
    drive(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk("arb grant count", order.size(), 10);
    cnt = 0;
    for (int g = 0; g < 10; g++) begin
      if (cnt == 4) begin e = 1; cnt = 0; end else begin e = 0; cnt++; end
      if (g < order.size()) chk($sformatf("arb grant %0d", g), order[g], e);
    end
    repeat (6) @(negedge clock);

    // Requester 1 idle: every grant goes to requester 0.
    order.delete();
    ack1_seen = 0;
    drive(0, 1'b1, 1'b0, 4'h0, 13'h0005, 32'h0);
    for (int k = 0; k < 200 && order.size() < 6; k++) begin
      @(negedge clock);
      if (ack0) order.push_back(0);
      if (ack1) ack1_seen++;
    end
    drive(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk("solo grant count", order.size(), 6);
    chk("solo no ack1", ack1_seen, 0);
    repeat (6) @(negedge clock);

    // req1 raised while a requester-0 RMW is in flight.
    drive(0, 1'b1, 1'b1, 4'b0011, 13'h0030, 32'hCAFEBABE);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin @(negedge clock); if (ack0) seen = 1; end
    drive(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk("holdoff ack0", {31'b0, seen}, 1);
    ref_mem[13'h0030] = merge_word(ref_mem[13'h0030], 32'hCAFEBABE, 4'b0011);
    exp_wren_total++;
    @(negedge clock);
    drive(1, 1'b1, 1'b0, 4'h0, 13'h0030, 32'h0);
    seen = 0; was_busy = busy;
    for (int k = 0; k < 30 && !seen; k++) begin
      @(negedge clock);
      if (ack1) seen = 1; else if (busy) was_busy = 1;
    end
    drive(1, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk("holdoff ack1", {31'b0, seen}, 1);
    chk("holdoff busy at ack1", {31'b0, busy}, 0);
    chk("holdoff waited busy", {31'b0, was_busy}, 1);
    repeat (2) @(negedge clock);
    chk("holdoff rvalid1", {31'b0, rvalid1}, 1);
    chk("holdoff rdata", rdata, ref_mem[13'h0030]);
    repeat (3) @(negedge clock);

    // Reset asserted during the RMW_MERGE cycle drops the write.
    t = wren_total;
    drive(0, 1'b1, 1'b1, 4'b1100, 13'h0040, 32'hFFFFFFFF);
    seen = 0;
    for (int k = 0; k < 30 && !seen; k++) begin @(negedge clock); if (ack0) seen = 1; end
    drive(0, 1'b0, 1'b0, 4'h0, 13'h0, 32'h0);
    chk("rst ack0", {31'b0, seen}, 1);
    repeat (2) @(negedge clock);
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk($sformatf("rst ctrl@%0d", k), {26'b0, ack0, ack1, rvalid0, rvalid1, busy, ram_wren}, 0);
      chk($sformatf("rst addr@%0d", k), {19'b0, ram_addr}, 0);
      chk($sformatf("rst data@%0d", k), ram_data, 0);
      chk($sformatf("rst rdata@%0d", k), rdata, 0);
    end
    reset_n = 1'b1;
    repeat (4) @(negedge clock);
    chk("rst no wren", wren_total, t);
    run_cmd(0, 1'b0, 4'h0, 13'h0040, 32'h0, "rst keep");
    chk("rst keep value", last_rdata, 32'h0BADF00D);

    // Random traffic against the word model.
    for (int n = 0; n < 40; n++) begin
      int sel;
      logic [3:0] be;
      logic [12:0] a;
      sel = int'($urandom_range(0, 3));
      be  = (sel == 0) ? 4'h0 : (sel == 1) ? 4'hF : 4'($urandom_range(1, 14));
      a   = ($urandom_range(0, 7) == 0) ? 13'h1FFF : 13'h0100 + 13'($urandom_range(0, 7));
      run_cmd(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), be, a, $urandom,
              $sformatf("rnd%0d", n));
    end

    chk("wren total", wren_total, exp_wren_total);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/bram_port_a_arbiter.md
Name: bram_port_a_arbiter

Overview:
- Shares the 32-bit word port (port A) of the dual-port block RAM between two requesters.
  - Requester 0: CPU, the priority requester.
  - Requester 1: DMA/loader.
- Adds per-byte write masking. The RAM port has no byte lanes, so partial writes are done as read-modify-write.
- Port B (8-bit) stays owned by the video side and is not touched by this block.

Parameters:
- DATA_W, 32: word width; must match the RAM port A width.
- ADDR_W, 13: word address width; matches RAM port A address width.
- STARVE_LIMIT, 4: consecutive requester-0 grants allowed while requester 1 waits.

Ports:
- clock  in  1  single clock for block and RAM port A
- reset_n  in  1  synchronous, active-low reset
- req0 / req1  in  1  request; held with its command fields until the matching ack
- we0 / we1  in  1  1 = write, 0 = read
- be0 / be1  in  DATA_W/8  byte enables for writes; ignored for reads
- addr0 / addr1  in  ADDR_W  word address
- wdata0 / wdata1  in  DATA_W  write data
- ack0 / ack1  out  1  one-cycle pulse: command accepted and captured
- rvalid0 / rvalid1  out  1  one-cycle pulse: rdata holds read result for that requester
- rdata  out  DATA_W  shared read-data bus
- busy  out  1  high in every state except IDLE
- ram_wren  out  1  to RAM wren_a
- ram_addr  out  ADDR_W  to RAM address_a
- ram_data  out  DATA_W  to RAM data_a
- ram_q  in  DATA_W  from RAM q_a; registered, valid the cycle after the address is presented

Behaviour:
- States: IDLE, RD_ADDR, RD_DATA, WR, RMW_ADDR, RMW_MERGE, RMW_WR.
- Reset (reset_n=0 at a clock edge):
  - state ← IDLE; starve counter ← 0.
  - ack*, rvalid*, ram_wren, busy ← 0; ram_addr, ram_data, rdata ← 0.
  - An in-flight command is dropped: no write is issued and no rvalid.
- IDLE, no request: ram_wren=0.
- IDLE, arbitration when any req is high:
  - Default winner is requester 0.
  - Requester 1 wins if only req1 is high, or if starve_cnt == STARVE_LIMIT.
- IDLE, on grant:
  - ack of the winner = 1 for exactly this cycle.
  - Command latched (id, we, be, addr, wdata); ram_addr ← addr registered.
- Starve counter:
  - Increments on each grant to 0 while req1 is high; saturates at STARVE_LIMIT.
  - Clears on a grant to 1, or whenever req1 is low.
- Read (accept cycle T):
  - T+1 RD_ADDR: RAM samples ram_addr.
  - T+2 RD_DATA: rdata = ram_q; rvalid of owner = 1.
  - T+3 back in IDLE.
  - Latency is 2 cycles from ack to rvalid.
- Full write (be all ones):
  - T+1 WR: ram_wren=1, ram_data=wdata.
  - T+2 IDLE.
- Partial write (be neither all zeros nor all ones):
  - T+1 RMW_ADDR: read.
  - T+2 RMW_MERGE: merged = per-byte (be[i] ? wdata : ram_q).
  - T+3 RMW_WR: ram_wren=1, ram_data=merged.
  - T+4 IDLE.
  - No rvalid is issued for any write.
- Null write (be = 0): acked, returns to IDLE next cycle, no RAM write.
- ram_wren is registered and high in exactly one cycle per non-null write.
- Accept only in IDLE: a request raised while busy waits; req held high with no ack is legal.
- A requester dropping req before its ack is allowed; it is simply not granted.
- All outputs are registered except rdata, which is ram_q gated to 0 outside RD_DATA.

Decomposition:
- Package bram_arb_pkg holds:
  - the state_t enum;
  - a requester-id typedef (1 bit);
  - a BE_FULL constant.
- Sub-module bram_byte_merge: combinational per-byte mux of wdata/ram_q under be, parameterised by DATA_W.

Test Plan:
- Read: preload word 0x0005=0x11223344; req0 read addr 0x0005 → ack0 at T, rvalid0 at T+2, rdata=0x11223344, ram_wren never high.
- Full write then read: req1 we, be=4'hF, addr 0x1FFF, wdata=0xDEADBEEF → ram_wren one cycle at T+1; a following read returns 0xDEADBEEF (top address, no wrap).
- RMW: word 0x0010=0xAABBCCDD; req0 write be=4'b0101, wdata=0x11223344 → single ram_wren at T+3 with ram_data=0xAA22CC44; neighbouring word unchanged.
- Arbitration / starvation: req0 and req1 held high continuously with STARVE_LIMIT=4 → grant order 0,0,0,0,1,0,0,0,0,1; with req1 low, req0 gets every grant.
- Null write and busy hold-off:
  - be=0 write → ack, no ram_wren, busy for 1 cycle.
  - req1 raised during a busy req0 RMW → ack1 only after return to IDLE.
- Reset mid-RMW: reset_n=0 in the RMW_MERGE cycle → no ram_wren at any later edge, state IDLE, all outputs 0, RAM word retains its old value.
